axi_ram_rd_arbiter: RTL and testbench

Round-robin arbiter that shares the AXI4 read channel (AR/R) of one axi_ram instance between S_COUNT simple burst-read requesters. It serialises requests, issues one INCR burst at a time on the master AR channel, and steers the R beats back to the granted requester. Sits between the instruction/data fetch front-ends and the shared RAM. Write channels are out of scope.

---
 rtl/axi_ram_rd_arbiter.sv | 147 ++++++++++++++
 tb/tb_axi_ram_rd_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ram_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read channel (AR/R) between S_COUNT
// burst-read requesters. One INCR burst is outstanding at a time; R beats are
// passed straight through to the granted requester with no added latency.
//
// Handshake semantics: every valid/ready pair transfers on a rising edge where
// both are high. A requester holds req_valid and its addr/len stable until it
// sees req_ready (a one-cycle pulse in IDLE); arvalid and all AR fields stay
// stable until arready; a beat transfers when m_axi_rvalid && m_axi_rready.
module axi_ram_rd_arbiter #(
  parameter int S_COUNT    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [S_COUNT-1:0]            req_valid,
  output logic [S_COUNT-1:0]            req_ready,
  input  logic [S_COUNT*ADDR_WIDTH-1:0] req_addr,
  input  logic [S_COUNT*8-1:0]          req_len,
  output logic [S_COUNT-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_last,
  input  logic [S_COUNT-1:0]            rsp_ready,
  output logic [ID_WIDTH-1:0]           m_axi_arid,
  output logic [ADDR_WIDTH-1:0]         m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [ID_WIDTH-1:0]           m_axi_rid,
  input  logic [DATA_WIDTH-1:0]         m_axi_rdata,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  output logic [1:0]                    dbg_state
);

  localparam int IDX_W = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  r_ptr;
  logic [IDX_W-1:0]  r_gnt;
  logic [IDX_W-1:0]  w_pick;
  logic [IDX_W-1:0]  w_ptr_nxt;
  logic [IDX_W:0]    w_idx;
  logic              w_any;
  logic              r_arvalid;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [7:0]        r_arlen;

  // Scan requesters starting at the rotation pointer, wrapping past S_COUNT-1.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_idx  = '0;
    for (int k = 0; k < S_COUNT; k++) begin
      w_idx = {1'b0, r_ptr} + (IDX_W+1)'(k);
      if (w_idx >= (IDX_W+1)'(S_COUNT)) w_idx = w_idx - (IDX_W+1)'(S_COUNT);
      if (!w_any && req_valid[w_idx[IDX_W-1:0]]) begin
        w_any  = 1'b1;
        w_pick = w_idx[IDX_W-1:0];
      end
    end
    w_ptr_nxt = (w_pick == IDX_W'(S_COUNT-1)) ? '0 : w_pick + IDX_W'(1);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic and the combinational request/response steering.
  always_comb begin
    w_state_nxt  = r_state;
    req_ready    = '0;
    rsp_valid    = '0;
    m_axi_rready = 1'b0;
    rsp_data     = m_axi_rdata;
    rsp_last     = m_axi_rlast;
    case (r_state)
      ST_IDLE: begin
        // Gated by rst so no acceptance pulse is seen while held in reset.
        if (w_any && rst) req_ready[w_pick] = 1'b1;
        if (w_any) w_state_nxt = ST_ADDR;
      end
      ST_ADDR: begin
        if (m_axi_arready) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        m_axi_rready     = rsp_ready[r_gnt];
        rsp_valid[r_gnt] = m_axi_rvalid;
        if (m_axi_rvalid && rsp_ready[r_gnt] && m_axi_rlast) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Latch the winner's AR fields and advance the rotation pointer past it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
      r_arlen   <= '0;
    end else begin
      if (r_state == ST_IDLE && w_any) begin
        r_gnt     <= w_pick;
        r_araddr  <= req_addr[w_pick*ADDR_WIDTH +: ADDR_WIDTH];
        r_arlen   <= req_len[w_pick*8 +: 8];
        r_arvalid <= 1'b1;
        r_ptr     <= w_ptr_nxt;
      end else if (r_state == ST_ADDR && m_axi_arready) begin
        r_arvalid <= 1'b0;
      end
    end
  end

  assign m_axi_arid    = ID_WIDTH'(r_gnt);
  assign m_axi_araddr  = r_araddr;
  assign m_axi_arlen   = r_arlen;
  assign m_axi_arsize  = 3'($clog2(DATA_WIDTH/8));
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = r_arvalid;
  assign dbg_state     = r_state;

`ifndef SYNTHESIS
  // Read data must come back under the ID of the burst currently granted.
  always @(posedge clk) begin
    if (rst && r_state == ST_DATA && m_axi_rvalid) begin
      assert (m_axi_rid == ID_WIDTH'(r_gnt))
        else $error("axi_ram_rd_arbiter: rid %0d does not match grant %0d", m_axi_rid, r_gnt);
    end
  end
`endif

endmodule

// File: tb/tb_axi_ram_rd_arbiter.sv
// Bench for axi_ram_rd_arbiter: directed steps plus a randomized phase, with a
// rotation model for grant order and an expected-beat queue for read data.
module tb_axi_ram_rd_arbiter;

  localparam int S  = 3;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int IW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [S-1:0]    req_valid;
  logic [S-1:0]    req_ready;
  logic [S*AW-1:0] req_addr;
  logic [S*8-1:0]  req_len;
  logic [S-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            rsp_last;
  logic [S-1:0]    rsp_ready;
  logic [IW-1:0]   m_axi_arid;
  logic [AW-1:0]   m_axi_araddr;
  logic [7:0]      m_axi_arlen;
  logic [2:0]      m_axi_arsize;
  logic [1:0]      m_axi_arburst;
  logic            m_axi_arvalid;
  logic            m_axi_arready;
  logic [IW-1:0]   m_axi_rid;
  logic [DW-1:0]   m_axi_rdata;
  logic            m_axi_rlast;
  logic            m_axi_rvalid;
  logic            m_axi_rready;
  logic [1:0]      dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_ptr = 0;
  logic [DW-1:0] exp_q[$];
  int g;

  axi_ram_rd_arbiter #(
    .S_COUNT(S), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .rsp_ready(rsp_ready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .dbg_state(dbg_state)
  );

  // Clock and time limit.
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1);
  end

  // RAM contents as a function of byte address.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a, ~a} ^ 32'h5a5a_0f0f;
  endfunction

  // First pending requester at or after ptr, wrapping; -1 if none.
  function automatic int pick(input logic [S-1:0] pend, input int ptr);
    for (int k = 0; k < S; k++) begin
      int i;
      i = (ptr + k) % S;
      if (pend[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [S-1:0] oh(input int i);
    logic [S-1:0] v;
    v = '0;
    if (i >= 0 && i < S) v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [7:0] l);
    req_valid[i]          = v;
    req_addr[i*AW +: AW]  = a;
    req_len[i*8 +: 8]     = l;
  endtask

  // One arbitration + AR + R sequence, starting in an IDLE cycle with requests
  // already driven. mode: 0 always ready, 1 ready toggles 1010, 2 random.
  // abort_at >= 0 returns with beat abort_at presented and not yet accepted.
  task automatic run_burst(input int stall, input int mode, input bit hold,
                           input int abort_at, output int g_obs);
    int ge;
    logic [AW-1:0] a;
    logic [7:0] l;
    int b;
    int cyc;
    #1;
    ge = pick(req_valid, exp_ptr);
    g_obs = -1;
    for (int i = 0; i < S; i++) if (req_ready[i]) g_obs = i;
    chk("req_ready_grant", req_ready, oh(ge));
    if (ge < 0) ge = 0;
    a = req_addr[ge*AW +: AW];
    l = req_len[ge*8 +: 8];
    for (int i = 0; i <= int'(l); i++) exp_q.push_back(mem_word(a + AW'(4*i)));
    exp_ptr = (ge + 1) % S;
    // Stray beats offered before the burst is in its data phase.
    m_axi_rvalid = 1'b1; m_axi_rdata = 32'hdead_beef; m_axi_rlast = 1'b1; m_axi_rid = IW'(ge);
    rsp_ready = '1;
    #1;
    chk("idle_no_rsp", {m_axi_rready, rsp_valid}, 0);
    tick;
    if (!hold) req_valid[ge] = 1'b0;
    for (int s = 0; s <= stall; s++) begin
      if (s == stall) m_axi_arready = 1'b1;
      #1;
      chk("arvalid", m_axi_arvalid, 1);
      chk("araddr", m_axi_araddr, a);
      chk("arlen", m_axi_arlen, l);
      chk("arsize", m_axi_arsize, 2);
      chk("arburst", m_axi_arburst, 1);
      chk("arid", m_axi_arid, ge);
      chk("addr_no_req_ready", req_ready, 0);
      chk("addr_no_rsp", {m_axi_rready, rsp_valid}, 0);
      tick;
    end
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    #1;
    chk("arvalid_drop", m_axi_arvalid, 0);
    b = 0; cyc = 0;
    while (b <= int'(l) && cyc < 200) begin
      m_axi_rvalid = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      m_axi_rdata  = mem_word(a + AW'(4*b));
      m_axi_rlast  = (b == int'(l));
      m_axi_rid    = IW'(ge);
      rsp_ready    = S'($urandom);
      rsp_ready[ge] = (mode == 1) ? (cyc % 2 == 0) : ((mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1);
      if (b == abort_at) return;
      #1;
      chk("rready_mirror", m_axi_rready, rsp_ready[ge]);
      chk("rsp_valid_steer", rsp_valid, m_axi_rvalid ? oh(ge) : 0);
      if (m_axi_rvalid && rsp_ready[ge]) begin
        chk("rsp_data", rsp_data, exp_q.pop_front());
        chk("rsp_last", rsp_last, b == int'(l));
        b++;
      end
      tick;
      cyc++;
    end
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; rsp_ready = '0;
    chk("burst_complete", b, int'(l) + 1);
  endtask

  initial begin
    rst = 1'b0;
    req_valid = '0; req_addr = '0; req_len = '0; rsp_ready = '0;
    m_axi_arready = 1'b0; m_axi_rid = '0; m_axi_rdata = '0;
    m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;

    // Reset state, with requests and beats pressing on the inputs.
    req_valid = 3'b011; m_axi_rvalid = 1'b1; rsp_ready = '1;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_araddr", m_axi_araddr, 0);
    chk("rst_arlen", m_axi_arlen, 0);
    chk("rst_arid", m_axi_arid, 0);
    chk("rst_rsp", {m_axi_rready, rsp_valid}, 0);
    chk("rst_state", dbg_state, 0);
    req_valid = '0; m_axi_rvalid = 1'b0; rsp_ready = '0;
    rst = 1'b1;
    tick;
    #1;
    chk("idle_quiet", req_ready, 0);
    tick;
    chk("idle_no_ar", m_axi_arvalid, 0);

    // Single request from requester 0, 4 beats.
    set_req(0, 1'b1, 16'h0040, 8'd3);
    run_burst(0, 0, 1'b0, -1, g);
    chk("single_grant", g, 0);

    // 8-beat burst for requester 1 under 1010 backpressure.
    set_req(1, 1'b1, 16'h0800, 8'd7);
    run_burst(0, 1, 1'b0, -1, g);
    chk("bp_grant", g, 1);
    #1;
    chk("bp_no_extra", m_axi_rready, 0);
    tick;

    // Contention: both held, single beats, alternating grants back to back.
    set_req(0, 1'b1, 16'h0100, 8'd0);
    set_req(1, 1'b1, 16'h0200, 8'd0);
    run_burst(0, 0, 1'b1, -1, g); chk("cont_order0", g, 0);
    run_burst(0, 0, 1'b1, -1, g); chk("cont_order1", g, 1);
    run_burst(0, 0, 1'b1, -1, g); chk("cont_order2", g, 0);
    run_burst(0, 0, 1'b1, -1, g); chk("cont_order3", g, 1);
    req_valid = '0;
    tick;

    // Requester 0 held across rlast: regranted in the very next cycle.
    set_req(0, 1'b1, 16'h0c00, 8'd1);
    run_burst(0, 0, 1'b1, -1, g); chk("b2b_first", g, 0);
    run_burst(0, 0, 1'b0, -1, g); chk("b2b_second", g, 0);

    // arready held low for 5 cycles.
    set_req(2, 1'b1, 16'h0a00, 8'd1);
    run_burst(5, 0, 1'b0, -1, g);
    chk("stall_grant", g, 2);

    // Randomized requests, withdrawals, stalls, gaps and backpressure.
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < S; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 1) == 1)
            set_req(i, 1'b1, AW'($urandom_range(0, 255) * 4), 8'($urandom_range(0, 5)));
        end else if ($urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      if (req_valid == '0)
        set_req(n % S, 1'b1, AW'($urandom_range(0, 255) * 4), 8'($urandom_range(0, 5)));
      run_burst($urandom_range(0, 2), 2, 1'b0, -1, g);
    end
    req_valid = '0;
    tick;

    // Reset asserted in the middle of a 4-beat burst.
    set_req(0, 1'b1, 16'h0300, 8'd3);
    run_burst(0, 0, 1'b0, 2, g);
    req_valid = 3'b111;
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_arvalid", m_axi_arvalid, 0);
    chk("midrst_req_ready", req_ready, 0);
    chk("midrst_rsp", {m_axi_rready, rsp_valid}, 0);
    chk("midrst_state", dbg_state, 0);
    exp_q.delete();
    exp_ptr = 0;
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; rsp_ready = '0; req_valid = '0;
    tick;
    rst = 1'b1;
    tick;
    set_req(1, 1'b1, 16'h0500, 8'd1);
    run_burst(0, 0, 1'b0, -1, g);
    chk("post_rst_grant", g, 1);
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
